// File: rtl/pb_debounce_if.sv
// Pushbutton debouncer signal bundle: raw active-low pad input in, clean level and event pulses out.
// The master side drives the pad input; the slave side is the debouncer.
interface pb_debounce_if;
    logic PB_raw;
    logic PB_db;
    logic pressed;
    logic long_press;

    modport master (
        output PB_raw,
        input  PB_db,
        input  pressed,
        input  long_press
    );

    modport slave (
        input  PB_raw,
        output PB_db,
        output pressed,
        output long_press
    );
endinterface

// File: rtl/pb_debounce.sv
// Active-low pushbutton front end: two-flop synchroniser, four-state debounce FSM with dwell counter,
// registered clean level, one-cycle press pulse and one-shot long-press pulse.
module pb_debounce #(
    parameter int DB_CYCLES         = 500_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    pb_debounce_if.slave  pb
);
    localparam int DW = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
    localparam int HW = ($clog2(LONG_PRESS_CYCLES) < 1) ? 1 : $clog2(LONG_PRESS_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {HI, CHK_LO, LO, CHK_HI} state_t;

    logic [1:0]    sync_reg;
    logic          s2;
    state_t        state_reg;
    logic [DW-1:0] dwell_reg;
    logic [HW-1:0] hold_reg;
    logic          fired_reg;
    logic          db_reg;
    logic          pressed_reg;
    logic          long_reg;

    // Synchroniser chain; stage 0 samples the pad, the last stage is all the FSM ever sees.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= pb.PB_raw;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign s2 = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HI;
            dwell_reg   <= '0;
            hold_reg    <= '0;
            fired_reg   <= 1'b0;
            db_reg      <= 1'b1;
            pressed_reg <= 1'b0;
            long_reg    <= 1'b0;
        end else begin
            pressed_reg <= 1'b0;
            long_reg    <= 1'b0;

            // Hold time accumulates for the whole accepted press, including a pending release check.
            if ((state_reg == LO || state_reg == CHK_HI) && hold_reg != HOLD_MAX) begin
                hold_reg <= hold_reg + 1'b1;
            end
            if (hold_reg == HOLD_MAX && !fired_reg) begin
                long_reg  <= 1'b1;
                fired_reg <= 1'b1;
            end

            case (state_reg)
                HI: begin
                    if (!s2) begin
                        state_reg <= CHK_LO;
                        dwell_reg <= '0;
                    end
                end
                CHK_LO: begin
                    if (s2) begin
                        state_reg <= HI;
                    end else if (dwell_reg == DWELL_MAX) begin
                        state_reg   <= LO;
                        db_reg      <= 1'b0;
                        pressed_reg <= 1'b1;
                        hold_reg    <= '0;
                        fired_reg   <= 1'b0;
                    end else begin
                        dwell_reg <= dwell_reg + 1'b1;
                    end
                end
                LO: begin
                    if (s2) begin
                        state_reg <= CHK_HI;
                        dwell_reg <= '0;
                    end
                end
                CHK_HI: begin
                    // A bounce back low resumes the press; the hold count keeps running.
                    if (!s2) begin
                        state_reg <= LO;
                    end else if (dwell_reg == DWELL_MAX) begin
                        state_reg <= HI;
                        db_reg    <= 1'b1;
                        hold_reg  <= '0;
                    end else begin
                        dwell_reg <= dwell_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= HI;
                end
            endcase
        end
    end

    assign pb.PB_db      = db_reg;
    assign pb.pressed    = pressed_reg;
    assign pb.long_press = long_reg;
endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: directed scenarios with literal expectations plus randomized button traffic,
// all checked every cycle against a run-length reference model of the debouncer.
module tb_pb_debounce;
    localparam int DB = 4;
    localparam int LP = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   press_cnt = 0;
    int   long_cnt = 0;

    pb_debounce_if pb_if ();

    pb_debounce #(
        .DB_CYCLES        (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pb   (pb_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the level seen by the FSM is the pad sampled two edges earlier. A level flips
    // once the opposite value has been seen on DB+1 consecutive edges. Press age counts edges spent
    // with the level low since the press; long press fires when the age reaches LP.
    logic m_db = 1'b1;
    logic m_pressed = 1'b0;
    logic m_long = 1'b0;
    int   m_run = 0;
    int   m_age = 0;
    logic hist[$] = '{1'b1, 1'b1};

    task automatic model_step();
        logic seen;
        logic was_db;
        if (!rst_n) begin
            m_db = 1'b1; m_pressed = 1'b0; m_long = 1'b0;
            m_run = 0; m_age = 0;
            hist = '{1'b1, 1'b1};
        end else begin
            seen = hist.pop_front();
            hist.push_back(pb_if.PB_raw);
            was_db = m_db;
            m_pressed = 1'b0;
            m_long = 1'b0;
            if (!was_db) begin
                m_age++;
                if (m_age == LP) m_long = 1'b1;
            end
            if (seen != was_db) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_db = seen;
                    m_run = 0;
                    if (!seen) begin
                        m_pressed = 1'b1;
                        m_age = 0;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("cycle_outputs", {29'd0, pb_if.PB_db, pb_if.pressed, pb_if.long_press},
            {29'd0, m_db, m_pressed, m_long});
        if (pb_if.pressed)    press_cnt++;
        if (pb_if.long_press) long_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pb0, lb0;

    initial begin
        pb_if.PB_raw = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        chk("reset_db", pb_if.PB_db, 1);
        chk("reset_pressed", pb_if.pressed, 0);
        chk("reset_long", pb_if.long_press, 0);
        rst_n = 1'b1;
        cyc(5);
        $display("reset released, PB_db=%0d", pb_if.PB_db);

        // Scenario 1 + 4: press from edge 1, held for 40 clocks past pressed
        pb0 = press_cnt; lb0 = long_cnt;
        pb_if.PB_raw = 1'b0;
        cyc(6);
        chk("s1_db_edge6", pb_if.PB_db, 1);
        cyc(1);
        chk("s1_db_edge7", pb_if.PB_db, 0);
        chk("s1_pressed_edge7", pb_if.pressed, 1);
        cyc(1);
        chk("s1_pressed_edge8", pb_if.pressed, 0);
        cyc(18);
        chk("s4_long_edge26", pb_if.long_press, 0);
        cyc(1);
        chk("s4_long_edge27", pb_if.long_press, 1);
        cyc(1);
        chk("s4_long_edge28", pb_if.long_press, 0);
        cyc(19);
        chk("s4_long_count", long_cnt - lb0, 1);
        chk("s4_press_count", press_cnt - pb0, 1);
        $display("scenario 1/4: press and long hold, presses=%0d longs=%0d", press_cnt - pb0, long_cnt - lb0);
        pb_if.PB_raw = 1'b1;
        cyc(10);
        chk("s4_released", pb_if.PB_db, 1);

        // Scenario 2: short glitch
        pb0 = press_cnt; lb0 = long_cnt;
        pb_if.PB_raw = 1'b0;
        cyc(3);
        pb_if.PB_raw = 1'b1;
        cyc(12);
        chk("s2_db", pb_if.PB_db, 1);
        chk("s2_press_count", press_cnt - pb0, 0);
        chk("s2_long_count", long_cnt - lb0, 0);
        $display("scenario 2: 3-clock glitch, presses=%0d", press_cnt - pb0);

        // Scenario 3: release bounce
        pb0 = press_cnt;
        pb_if.PB_raw = 1'b0;
        cyc(10);
        chk("s3_db_pressed", pb_if.PB_db, 0);
        pb_if.PB_raw = 1'b1; cyc(1);
        pb_if.PB_raw = 1'b0; cyc(1);
        pb_if.PB_raw = 1'b1; cyc(1);
        pb_if.PB_raw = 1'b0; cyc(1);
        pb_if.PB_raw = 1'b1;
        cyc(6);
        chk("s3_db_edge6", pb_if.PB_db, 0);
        cyc(1);
        chk("s3_db_edge7", pb_if.PB_db, 1);
        chk("s3_press_count", press_cnt - pb0, 1);
        $display("scenario 3: release bounce, presses=%0d", press_cnt - pb0);
        cyc(3);

        // Scenario 5: reset during an accepted press
        pb0 = press_cnt; lb0 = long_cnt;
        pb_if.PB_raw = 1'b0;
        cyc(8);
        chk("s5_db_before_reset", pb_if.PB_db, 0);
        rst_n = 1'b0;
        #1;
        chk("s5_db_async_reset", pb_if.PB_db, 1);
        cyc(2);
        chk("s5_db_in_reset", pb_if.PB_db, 1);
        chk("s5_pressed_in_reset", pb_if.pressed, 0);
        rst_n = 1'b1;
        cyc(6);
        chk("s5_db_edge6", pb_if.PB_db, 1);
        cyc(1);
        chk("s5_db_edge7", pb_if.PB_db, 0);
        chk("s5_pressed_edge7", pb_if.pressed, 1);
        chk("s5_press_count", press_cnt - pb0, 2);
        chk("s5_long_count", long_cnt - lb0, 0);
        $display("scenario 5: reset mid-press, presses=%0d", press_cnt - pb0);

        // Scenario 6: three release/re-press cycles of 10 clocks each
        pb0 = press_cnt; lb0 = long_cnt;
        for (int i = 0; i < 3; i++) begin
            pb_if.PB_raw = 1'b1; cyc(10);
            pb_if.PB_raw = 1'b0; cyc(10);
        end
        chk("s6_press_count", press_cnt - pb0, 3);
        chk("s6_long_count", long_cnt - lb0, 0);
        $display("scenario 6: repeated presses, presses=%0d longs=%0d", press_cnt - pb0, long_cnt - lb0);
        pb_if.PB_raw = 1'b1;
        cyc(10);

        // Randomized traffic: runs of random length, occasional reset pulses
        pb0 = press_cnt; lb0 = long_cnt;
        for (int r = 0; r < 200; r++) begin
            pb_if.PB_raw = ~pb_if.PB_raw;
            if ($urandom_range(0, 5) == 0) cyc($urandom_range(20, 35));
            else                           cyc($urandom_range(1, 10));
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                cyc($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        $display("random phase: presses=%0d longs=%0d", press_cnt - pb0, long_cnt - lb0);
        pb_if.PB_raw = 1'b1;
        cyc(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
